// File: rtl/pcie_ltssm_detect_poll_if.sv
// LTSSM Detect/Polling bundle: PHY status, OS decoder strobes, TX controls.
// master = LTSSM side (drives *_o), slave = PHY / ordered-set side (*_i).
interface pcie_ltssm_detect_poll_if #(
  parameter int NUM_LANES = 4
) ();
  logic                 restart_i;
  logic                 phy_rx_det_done_i;
  logic [NUM_LANES-1:0] phy_layer_lane_detect_i;
  logic [NUM_LANES-1:0] phy_rx_elec_idle_i;
  logic [NUM_LANES-1:0] rx_ts1_valid_i;
  logic [NUM_LANES-1:0] rx_ts2_valid_i;
  logic                 tx_os_done_i;
  logic                 rx_det_req_o;
  logic                 tx_elec_idle_o;
  logic                 tx_send_ts1_o;
  logic                 tx_send_ts2_o;
  logic                 tx_compliance_o;
  logic [NUM_LANES-1:0] lane_mask_o;
  logic [2:0]           substate_o;
  logic                 poll_done_o;
  logic                 timeout_o;

  modport master (
    input  restart_i,
    input  phy_rx_det_done_i,
    input  phy_layer_lane_detect_i,
    input  phy_rx_elec_idle_i,
    input  rx_ts1_valid_i,
    input  rx_ts2_valid_i,
    input  tx_os_done_i,
    output rx_det_req_o,
    output tx_elec_idle_o,
    output tx_send_ts1_o,
    output tx_send_ts2_o,
    output tx_compliance_o,
    output lane_mask_o,
    output substate_o,
    output poll_done_o,
    output timeout_o
  );

  modport slave (
    output restart_i,
    output phy_rx_det_done_i,
    output phy_layer_lane_detect_i,
    output phy_rx_elec_idle_i,
    output rx_ts1_valid_i,
    output rx_ts2_valid_i,
    output tx_os_done_i,
    input  rx_det_req_o,
    input  tx_elec_idle_o,
    input  tx_send_ts1_o,
    input  tx_send_ts2_o,
    input  tx_compliance_o,
    input  lane_mask_o,
    input  substate_o,
    input  poll_done_o,
    input  timeout_o
  );
endinterface

// File: rtl/pcie_ltssm_detect_poll.sv
// LTSSM front end: Detect.Quiet/Active, Polling.Active/Config, hand-off.
// Ports: clk_i, rst_i (sync, high), bus (master). Option: PCIE_POLL_COMPLIANCE_EN.
module pcie_ltssm_detect_poll #(
  parameter int NUM_LANES       = 4,
  parameter int QUIET_CYC       = 16,
  parameter int POLL_ACT_TO_CYC = 200,
  parameter int POLL_CFG_TO_CYC = 100,
  parameter int TS_TX_MIN       = 16,
  parameter int TS_RX_REQ       = 8,
  parameter int TS2_TX_MIN      = 4
) (
  input logic clk_i,
  input logic rst_i,
  pcie_ltssm_detect_poll_if.master bus
);
  localparam int TMA = (QUIET_CYC > POLL_ACT_TO_CYC) ?
                       QUIET_CYC : POLL_ACT_TO_CYC;
  localparam int TMX = (TMA > POLL_CFG_TO_CYC) ?
                       TMA : POLL_CFG_TO_CYC;
  localparam int TW  = $clog2(TMX) + 1;
  localparam int XMX = (TS_TX_MIN > TS2_TX_MIN) ?
                       TS_TX_MIN : TS2_TX_MIN;
  localparam int XW  = $clog2(XMX + 1);
  localparam int RW  = $clog2(TS_RX_REQ + 1);

  localparam logic [TW-1:0] T_QUIET = TW'(QUIET_CYC - 1);
  localparam logic [TW-1:0] T_PACT  = TW'(POLL_ACT_TO_CYC - 1);
  localparam logic [TW-1:0] T_PCFG  = TW'(POLL_CFG_TO_CYC - 1);
  localparam logic [XW-1:0] TX1_MIN = XW'(TS_TX_MIN);
  localparam logic [XW-1:0] TX2_MIN = XW'(TS2_TX_MIN);
  localparam logic [RW-1:0] RX_REQ  = RW'(TS_RX_REQ);

  localparam logic [2:0] ST_DQ = 3'd0;
  localparam logic [2:0] ST_DA = 3'd1;
  localparam logic [2:0] ST_PA = 3'd2;
  localparam logic [2:0] ST_PC = 3'd3;
  localparam logic [2:0] ST_PD = 3'd4;
`ifdef PCIE_POLL_COMPLIANCE_EN
  localparam logic [2:0] ST_CP = 3'd5;
`endif

  logic [2:0]           st;
  logic [2:0]           st_nxt;
  logic [TW-1:0]        tmr;
  logic [XW-1:0]        tx_cnt;
  logic [RW-1:0]        rx_cnt [NUM_LANES];
  logic [NUM_LANES-1:0] mask;
  logic [NUM_LANES-1:0] mask_nxt;
  logic [NUM_LANES-1:0] rx_ok;
  logic [NUM_LANES-1:0] rx_hit;
  logic [NUM_LANES-1:0] qual;
  logic                 first_ts2;
  logic                 ts2_seen;
  logic                 all_ok;
  logic                 tx_inc;
  logic                 entry;
  logic                 to_ev;
`ifdef PCIE_POLL_COMPLIANCE_EN
  logic [NUM_LANES-1:0] idle_all;
`endif

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      rx_ok[i] = rx_cnt[i] >= RX_REQ;
    end
  end

  assign qual     = rx_ok & mask;
  assign all_ok   = &(rx_ok | ~mask);
  assign ts2_seen = |(bus.rx_ts2_valid_i & mask);

  always_comb begin
    rx_hit = '0;
    if (st == ST_PA) begin
      rx_hit = (bus.rx_ts1_valid_i | bus.rx_ts2_valid_i) & mask;
    end else if (st == ST_PC) begin
      rx_hit = bus.rx_ts2_valid_i & mask;
    end
  end

  // TS2 transmit count only starts once the partner has sent a TS2.
  assign tx_inc = bus.tx_os_done_i &
                  ((st == ST_PA) |
                   ((st == ST_PC) & (first_ts2 | ts2_seen)));

  always_comb begin
    st_nxt   = st;
    mask_nxt = mask;
    to_ev    = 1'b0;
    unique case (st)
      ST_DQ: begin
        if (tmr >= T_QUIET || !(&bus.phy_rx_elec_idle_i)) begin
          st_nxt = ST_DA;
        end
      end
      ST_DA: begin
        if (bus.phy_rx_det_done_i) begin
          if (|bus.phy_layer_lane_detect_i) begin
            mask_nxt = bus.phy_layer_lane_detect_i;
            st_nxt   = ST_PA;
          end else begin
            st_nxt = ST_DQ;
          end
        end
      end
      ST_PA: begin
        if (tx_cnt >= TX1_MIN && all_ok) begin
          st_nxt = ST_PC;
        end else if (tmr >= T_PACT) begin
          if (|qual) begin
            st_nxt   = ST_PC;
            mask_nxt = qual;
          end
`ifdef PCIE_POLL_COMPLIANCE_EN
          else if (|(mask & idle_all &
                     bus.phy_rx_elec_idle_i)) begin
            st_nxt = ST_CP;
          end
`endif
          else begin
            st_nxt   = ST_DQ;
            mask_nxt = '0;
            to_ev    = 1'b1;
          end
        end
      end
      ST_PC: begin
        if (tx_cnt >= TX2_MIN && all_ok) begin
          st_nxt = ST_PD;
        end else if (tmr >= T_PCFG) begin
          st_nxt   = ST_DQ;
          mask_nxt = '0;
          to_ev    = 1'b1;
        end
      end
      ST_PD: begin
        st_nxt = ST_PD;
      end
`ifdef PCIE_POLL_COMPLIANCE_EN
      ST_CP: begin
        if (&(~bus.phy_rx_elec_idle_i | ~mask)) begin
          st_nxt = ST_PA;
        end
      end
`endif
      default: begin
        st_nxt   = ST_DQ;
        mask_nxt = '0;
      end
    endcase
    if (bus.restart_i) begin
      st_nxt   = ST_DQ;
      mask_nxt = '0;
      to_ev    = 1'b0;
    end
  end

  assign entry = (st_nxt != st) | bus.restart_i;

  assign bus.substate_o  = st;
  assign bus.lane_mask_o = mask;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st                  <= ST_DQ;
      mask                <= '0;
      tmr                 <= '0;
      tx_cnt              <= '0;
      first_ts2           <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rx_cnt[i] <= '0;
      end
      bus.rx_det_req_o    <= 1'b0;
      bus.tx_elec_idle_o  <= 1'b1;
      bus.tx_send_ts1_o   <= 1'b0;
      bus.tx_send_ts2_o   <= 1'b0;
      bus.tx_compliance_o <= 1'b0;
      bus.poll_done_o     <= 1'b0;
      bus.timeout_o       <= 1'b0;
    end else begin
      st   <= st_nxt;
      mask <= mask_nxt;
      if (entry) begin
        tmr <= '0;
      end else if (tmr != '1) begin
        tmr <= tmr + TW'(1);
      end
      if (entry) begin
        tx_cnt <= '0;
      end else if (tx_inc && tx_cnt != '1) begin
        tx_cnt <= tx_cnt + XW'(1);
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (entry) begin
          rx_cnt[i] <= '0;
        end else if (rx_hit[i] && rx_cnt[i] != '1) begin
          rx_cnt[i] <= rx_cnt[i] + RW'(1);
        end
      end
      if (entry) begin
        first_ts2 <= 1'b0;
      end else if (st == ST_PC && ts2_seen) begin
        first_ts2 <= 1'b1;
      end
      bus.rx_det_req_o   <= (st_nxt == ST_DA) && (st != ST_DA);
      bus.tx_elec_idle_o <= (st_nxt == ST_DQ) || (st_nxt == ST_DA);
      bus.tx_send_ts1_o  <= st_nxt == ST_PA;
      bus.tx_send_ts2_o  <= (st_nxt == ST_PC) || (st_nxt == ST_PD);
      bus.poll_done_o    <= st_nxt == ST_PD;
      bus.timeout_o      <= to_ev;
`ifdef PCIE_POLL_COMPLIANCE_EN
      bus.tx_compliance_o <= st_nxt == ST_CP;
`else
      bus.tx_compliance_o <= 1'b0;
`endif
    end
  end

`ifdef PCIE_POLL_COMPLIANCE_EN
  // Sticky AND of RX idle over the Polling.Active visit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_all <= '1;
    end else if (entry) begin
      idle_all <= '1;
    end else begin
      idle_all <= idle_all & bus.phy_rx_elec_idle_i;
    end
  end
`endif
endmodule

// File: tb/tb_pcie_ltssm_detect_poll.sv
// Randomized bench for pcie_ltssm_detect_poll against a rule-level model.
// Stimulus is pre-generated per state visit; exits are predicted from it.
module tb_pcie_ltssm_detect_poll;
  localparam int NL    = 4;
  localparam int QUIET = 16;
  localparam int PA_TO = 200;
  localparam int PC_TO = 100;
  localparam int TX1   = 16;
  localparam int RXQ   = 8;
  localparam int TX2   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcie_ltssm_detect_poll_if #(.NUM_LANES(NL)) bus ();

  pcie_ltssm_detect_poll #(
    .NUM_LANES      (NL),
    .QUIET_CYC      (QUIET),
    .POLL_ACT_TO_CYC(PA_TO),
    .POLL_CFG_TO_CYC(PC_TO),
    .TS_TX_MIN      (TX1),
    .TS_RX_REQ      (RXQ),
    .TS2_TX_MIN     (TX2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit            tx_a [PA_TO];
  logic [NL-1:0] ts_a [PA_TO];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("tx_onehot",
        32'($countones({bus.tx_send_ts1_o,
                        bus.tx_send_ts2_o,
                        bus.tx_compliance_o}) <= 1), 1);
  end

  task automatic strobes_off();
    bus.restart_i               = 1'b0;
    bus.phy_rx_det_done_i       = 1'b0;
    bus.phy_layer_lane_detect_i = '0;
    bus.rx_ts1_valid_i          = '0;
    bus.rx_ts2_valid_i          = '0;
    bus.tx_os_done_i            = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_st"},    bus.substate_o, 0);
    chk({tag, "_eidle"}, bus.tx_elec_idle_o, 1);
    chk({tag, "_mask"},  bus.lane_mask_o, 0);
    chk({tag, "_ts1"},   bus.tx_send_ts1_o, 0);
    chk({tag, "_ts2"},   bus.tx_send_ts2_o, 0);
    chk({tag, "_comp"},  bus.tx_compliance_o, 0);
    chk({tag, "_dreq"},  bus.rx_det_req_o, 0);
    chk({tag, "_pdone"}, bus.poll_done_o, 0);
    chk({tag, "_to"},    bus.timeout_o, 0);
  endtask

  // Fill the stimulus table; lane cl gets at most cap pulses in total.
  task automatic gen(input int p_tx, input int p_rx,
                     input int cl, input int cap);
    int given = 0;
    for (int j = 0; j < PA_TO; j++) begin
      tx_a[j] = $urandom_range(0, 99) < p_tx;
      for (int l = 0; l < NL; l++) begin
        ts_a[j][l] = $urandom_range(0, 99) < p_rx;
        if (l == cl) begin
          if (given >= cap) ts_a[j][l] = 1'b0;
          if (ts_a[j][l]) given++;
        end
      end
    end
  endtask

  // Must be called from a Detect state at a negedge.
  task automatic detect(input logic [NL-1:0] m);
    int n = 0;
    while (bus.substate_o != 3'd1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("det_wait", 32'(n < 64), 1);
    chk("det_req", bus.rx_det_req_o, 1);
    bus.phy_rx_det_done_i       = 1'b1;
    bus.phy_layer_lane_detect_i = m;
    @(negedge clk);
    strobes_off();
    chk("pa_entry", bus.substate_o, 2);
    chk("pa_mask", bus.lane_mask_o, 32'(m));
    chk("pa_eidle", bus.tx_elec_idle_o, 0);
    chk("pa_ts1", bus.tx_send_ts1_o, 1);
  endtask

  // Entered at the negedge of the first Polling.Active cycle.
  task automatic run_pa(input logic [NL-1:0] m,
                        input logic [NL-1:0] idle_pa,
                        output logic [NL-1:0] m_out,
                        output int st_out);
    int ctx = 0;
    int cr [NL];
    int last = 0;
    bit ex = 1'b0;
    bit all;
    logic [NL-1:0] qual = '0;
    logic [NL-1:0] sel;
    for (int l = 0; l < NL; l++) cr[l] = 0;
    for (int j = 0; j < PA_TO; j++) begin
      all = 1'b1;
      for (int l = 0; l < NL; l++)
        if (m[l] && cr[l] < RXQ) all = 1'b0;
      last = j;
      if (ctx >= TX1 && all) begin
        ex = 1'b1;
        break;
      end
      if (j == PA_TO - 1) break;
      ctx += int'(tx_a[j]);
      for (int l = 0; l < NL; l++)
        if (m[l] && ts_a[j][l]) cr[l]++;
    end
    for (int l = 0; l < NL; l++)
      qual[l] = m[l] && cr[l] >= RXQ;
    bus.phy_rx_elec_idle_i = idle_pa;
    for (int j = 0; j <= last; j++) begin
      if (j > 0) @(negedge clk);
      chk("pa_stay", bus.substate_o, 2);
      sel = NL'($urandom);
      bus.rx_ts1_valid_i = ts_a[j] & sel;
      bus.rx_ts2_valid_i = ts_a[j] & ~sel;
      bus.tx_os_done_i   = tx_a[j];
    end
    @(negedge clk);
    strobes_off();
    if (ex || qual != '0) begin
      m_out  = ex ? m : qual;
      st_out = 3;
      chk("pa_exit_st", bus.substate_o, 3);
      chk("pa_exit_mask", bus.lane_mask_o, 32'(m_out));
      chk("pa_exit_to", bus.timeout_o, 0);
      chk("pc_ts2", bus.tx_send_ts2_o, 1);
    end else begin
`ifdef PCIE_POLL_COMPLIANCE_EN
      if ((m & idle_pa) != '0) begin
        m_out  = m;
        st_out = 5;
        chk("cp_st", bus.substate_o, 5);
        chk("cp_tx", bus.tx_compliance_o, 1);
        chk("cp_eidle", bus.tx_elec_idle_o, 0);
        chk("cp_mask", bus.lane_mask_o, 32'(m));
        return;
      end
`endif
      m_out  = '0;
      st_out = 0;
      chk("pa_to_st", bus.substate_o, 0);
      chk("pa_to_pulse", bus.timeout_o, 1);
      chk("pa_to_mask", bus.lane_mask_o, 0);
      chk("pa_to_eidle", bus.tx_elec_idle_o, 1);
      @(negedge clk);
      chk("pa_to_pulse1", bus.timeout_o, 0);
    end
  endtask

  // Entered at the negedge of the first Polling.Configuration cycle.
  task automatic run_pc(input logic [NL-1:0] m, input int p_ts2);
    int ctx = 0;
    int cr [NL];
    int last = 0;
    bit ex = 1'b0;
    bit seen = 1'b0;
    bit all;
    gen(50, p_ts2, 0, 1000);
    for (int l = 0; l < NL; l++) cr[l] = 0;
    for (int j = 0; j < PC_TO; j++) begin
      all = 1'b1;
      for (int l = 0; l < NL; l++)
        if (m[l] && cr[l] < RXQ) all = 1'b0;
      last = j;
      if (ctx >= TX2 && all) begin
        ex = 1'b1;
        break;
      end
      if (j == PC_TO - 1) break;
      if ((ts_a[j] & m) != '0) seen = 1'b1;
      if (seen && tx_a[j]) ctx++;
      for (int l = 0; l < NL; l++)
        if (m[l] && ts_a[j][l]) cr[l]++;
    end
    for (int j = 0; j <= last; j++) begin
      if (j > 0) @(negedge clk);
      chk("pc_stay", bus.substate_o, 3);
      bus.rx_ts1_valid_i = NL'($urandom);
      bus.rx_ts2_valid_i = ts_a[j];
      bus.tx_os_done_i   = tx_a[j];
    end
    @(negedge clk);
    strobes_off();
    if (ex) begin
      chk("pd_st", bus.substate_o, 4);
      chk("pd_done", bus.poll_done_o, 1);
      chk("pd_ts2", bus.tx_send_ts2_o, 1);
      chk("pd_mask", bus.lane_mask_o, 32'(m));
      chk("pd_to", bus.timeout_o, 0);
    end else begin
      chk("pc_to_st", bus.substate_o, 0);
      chk("pc_to_pulse", bus.timeout_o, 1);
      chk("pc_to_mask", bus.lane_mask_o, 0);
      @(negedge clk);
      chk("pc_to_pulse1", bus.timeout_o, 0);
    end
  endtask

  initial begin
    logic [NL-1:0] m;
    logic [NL-1:0] mo;
    int so;
    int k;
    strobes_off();
    bus.phy_rx_elec_idle_i = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    for (int q = 0; q < QUIET; q++) begin
      if (q > 0) @(negedge clk);
      chk("dq_dwell", bus.substate_o, 0);
      chk("dq_eidle", bus.tx_elec_idle_o, 1);
    end
    @(negedge clk);
    chk("da_st", bus.substate_o, 1);
    chk("da_req", bus.rx_det_req_o, 1);
    chk("da_eidle", bus.tx_elec_idle_o, 1);
    @(negedge clk);
    chk("da_req_once", bus.rx_det_req_o, 0);
    chk("da_hold", bus.substate_o, 1);
    bus.phy_rx_det_done_i = 1'b1;
    @(negedge clk);
    strobes_off();
    chk("da_zero", bus.substate_o, 0);

    k = $urandom_range(0, 14);
    for (int q = 0; q <= k; q++) begin
      if (q > 0) @(negedge clk);
      chk("dq_early", bus.substate_o, 0);
    end
    bus.phy_rx_elec_idle_i = ~(NL'(1) << $urandom_range(0, NL - 1));
    @(negedge clk);
    bus.phy_rx_elec_idle_i = '1;
    chk("dq_idle_exit", bus.substate_o, 1);

    detect(4'b1011);
    gen(50, 45, 0, 1000);
    run_pa(4'b1011, '0, mo, so);
    chk("ok_pa_path", 32'(so), 3);
    run_pc(mo, 45);
    repeat (3) begin
      @(negedge clk);
      chk("pd_stay", bus.substate_o, 4);
      chk("pd_done_hold", bus.poll_done_o, 1);
      chk("pd_mask_hold", bus.lane_mask_o, 4'b1011);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("pd_rst");

    bus.phy_rx_elec_idle_i = '0;
    detect(4'b1111);
    gen(50, 45, 2, 3);
    run_pa(4'b1111, '0, mo, so);
    chk("shrink_mask", 32'(mo), 4'b1011);
    run_pc(mo, 0);

    bus.phy_rx_elec_idle_i = 4'b0010;
    detect(4'b1111);
    gen(50, 0, 0, 1000);
    run_pa(4'b1111, 4'b0010, mo, so);
`ifdef PCIE_POLL_COMPLIANCE_EN
    repeat (3) begin
      @(negedge clk);
      chk("cp_stay", bus.substate_o, 5);
    end
    bus.phy_rx_elec_idle_i = '0;
    @(negedge clk);
    chk("cp_exit", bus.substate_o, 2);
    chk("cp_exit_ts1", bus.tx_send_ts1_o, 1);
    chk("cp_exit_comp", bus.tx_compliance_o, 0);
`else
    bus.phy_rx_elec_idle_i = '0;
    detect(NL'($urandom_range(1, 15)));
`endif

    k = $urandom_range(1, 30);
    repeat (k) begin
      @(negedge clk);
      chk("rs_pa", bus.substate_o, 2);
      bus.rx_ts1_valid_i = NL'($urandom);
      bus.tx_os_done_i   = 1'($urandom);
    end
    bus.restart_i = 1'b1;
    @(negedge clk);
    strobes_off();
    chk_reset_vals("restart");

    m = NL'($urandom_range(1, 15));
    detect(m);
    gen(50, 45, 0, 1000);
    run_pa(m, '0, mo, so);
    chk("rs_pa_path", 32'(so), 3);
    run_pc(mo, 45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end, %0d mismatched", n_bad);
    $fatal(1, "watchdog");
  end
endmodule
